// File: rtl/qa_7seg_pkg.sv
// Shared constants for the 7-segment readback decoder: glyph ROM values,
// the optional alternate glyphs and the sequencer state encoding.
package qa_7seg_pkg;

  localparam int SEG_PER_DIGIT = 7;
  localparam int NIB_W         = 4;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}; must track the encoder ROM.
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Alternate 7 (with f) and 9 (without d); 6-without-a collides with b.
  localparam logic [6:0] ALT_GLYPH_7 = 7'h27;
  localparam logic [6:0] ALT_GLYPH_9 = 7'h67;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/qa_7seg_decoder_glyph_lookup.sv
// Combinational pattern-to-nibble lookup for one active-high digit.
// QA_7SEG_DEC_ALT_GLYPH_EN additionally accepts the alternate 7 and 9 glyphs.
module qa_7seg_glyph_lookup
  import qa_7seg_pkg::*;
(
  input  logic [SEG_PER_DIGIT-1:0] i_pattern,
  output logic [NIB_W-1:0]         o_nibble,
  output logic                     o_valid,
  output logic                     o_blank
);

  always_comb begin
    o_nibble = '0;
    o_valid  = 1'b1;
    o_blank  = 1'b0;
    case (i_pattern)
      GLYPH_0: o_nibble = 4'h0;
      GLYPH_1: o_nibble = 4'h1;
      GLYPH_2: o_nibble = 4'h2;
      GLYPH_3: o_nibble = 4'h3;
      GLYPH_4: o_nibble = 4'h4;
      GLYPH_5: o_nibble = 4'h5;
      GLYPH_6: o_nibble = 4'h6;
      GLYPH_7: o_nibble = 4'h7;
      GLYPH_8: o_nibble = 4'h8;
      GLYPH_9: o_nibble = 4'h9;
      GLYPH_A: o_nibble = 4'hA;
      GLYPH_B: o_nibble = 4'hB;
      GLYPH_C: o_nibble = 4'hC;
      GLYPH_D: o_nibble = 4'hD;
      GLYPH_E: o_nibble = 4'hE;
      GLYPH_F: o_nibble = 4'hF;
`ifdef QA_7SEG_DEC_ALT_GLYPH_EN
      ALT_GLYPH_7: o_nibble = 4'h7;
      ALT_GLYPH_9: o_nibble = 4'h9;
`endif
      SEG_BLANK: begin
        o_valid = 1'b0;
        o_blank = 1'b1;
      end
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/qa_7seg_decoder.sv
// Sequential 7-segment readback: captures the segment bus on start and decodes
// one digit per clock. Optional macro: QA_7SEG_DEC_ALT_GLYPH_EN (alternate glyphs).
module qa_7seg_decoder
  import qa_7seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [SEG_PER_DIGIT*NUM_DIGITS-1:0] segments,
  output logic                              busy,
  output logic                              done,
  output logic [NIB_W*NUM_DIGITS-1:0]       data,
  output logic [NUM_DIGITS/2-1:0]           enable,
  output logic [NUM_DIGITS-1:0]             digit_valid,
  output logic                              error
);

  localparam int SEG_W = SEG_PER_DIGIT * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                    r_state, w_next;
  logic [SEG_W-1:0]          r_shadow;
  logic [IDX_W-1:0]          r_idx;
  logic [NUM_DIGITS-1:0]     r_blank;
  logic [NIB_W*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS/2-1:0]   r_enable;
  logic [NUM_DIGITS-1:0]     r_valid;
  logic                      r_error;
  logic                      r_done;

  logic [SEG_W-1:0]          w_capture;
  logic [SEG_PER_DIGIT-1:0]  w_pattern;
  logic [NIB_W-1:0]          w_nibble;
  logic                      w_valid;
  logic                      w_blank;
  logic                      w_last;
  logic [NUM_DIGITS/2-1:0]   w_enable;

  assign w_capture = ACTIVE_LOW ? ~segments : segments;
  assign w_pattern = r_shadow[int'(r_idx)*SEG_PER_DIGIT +: SEG_PER_DIGIT];
  assign w_last    = (r_idx == LAST_IDX);

  qa_7seg_glyph_lookup u_lookup (
    .i_pattern (w_pattern),
    .o_nibble  (w_nibble),
    .o_valid   (w_valid),
    .o_blank   (w_blank)
  );

  // A pair stays lit unless both of its digits decoded as blank.
  for (genvar k = 0; k < NUM_DIGITS/2; k++) begin : g_pair
    assign w_enable[k] = ~(r_blank[2*k] & r_blank[2*k+1]);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = DECODE;
      DECODE:  if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_idx    <= '0;
      r_blank  <= '0;
      r_data   <= '0;
      r_enable <= '0;
      r_valid  <= '0;
      r_error  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shadow <= w_capture;
            r_idx    <= '0;
            r_valid  <= '0;
            r_error  <= 1'b0;
          end
        end
        DECODE: begin
          r_data[int'(r_idx)*NIB_W +: NIB_W] <= w_nibble;
          r_valid[r_idx] <= w_valid;
          r_blank[r_idx] <= w_blank;
          if (!w_valid && !w_blank) r_error <= 1'b1;
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        DONE:    r_enable <= w_enable;
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign data        = r_data;
  assign enable      = r_enable;
  assign digit_valid = r_valid;
  assign error       = r_error;

endmodule

// File: tb/tb_qa_7seg_decoder.sv
// Scoreboard bench for qa_7seg_decoder: directed bus patterns, expected
// results queued at start and checked by a monitor on each done pulse.
module tb_qa_7seg_decoder;

  typedef struct packed {
    logic [23:0] data;
    logic [2:0]  enable;
    logic [5:0]  valid;
    logic        error;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [41:0] segments;
  logic        busy, done, error;
  logic [23:0] data;
  logic [2:0]  enable;
  logic [5:0]  digit_valid;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  qa_7seg_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .segments    (segments),
    .busy        (busy),
    .done        (done),
    .data        (data),
    .enable      (enable),
    .digit_valid (digit_valid),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F; 4'h1: glyph = 7'h06; 4'h2: glyph = 7'h5B; 4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66; 4'h5: glyph = 7'h6D; 4'h6: glyph = 7'h7D; 4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F; 4'h9: glyph = 7'h6F; 4'hA: glyph = 7'h77; 4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39; 4'hD: glyph = 7'h5E; 4'hE: glyph = 7'h79; default: glyph = 7'h71;
    endcase
  endfunction

  // Active-low bus as the on-board encoder would drive it.
  function automatic logic [41:0] enc(input logic [23:0] d, input logic [2:0] en);
    logic [41:0] b;
    for (int k = 0; k < 6; k++)
      b[7*k +: 7] = en[k/2] ? ~glyph(d[4*k +: 4]) : 7'h7F;
    return b;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("data",        {8'h0, data},         {8'h0, e.data});
        chk("enable",      {29'h0, enable},      {29'h0, e.enable});
        chk("digit_valid", {26'h0, digit_valid}, {26'h0, e.valid});
        chk("error",       {31'h0, error},       {31'h0, e.error});
      end
    end
  end

  task automatic wait_done(input int expect_lat);
    int k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    else if (expect_lat >= 0) chk("latency", k, expect_lat);
    @(negedge clk);
  endtask

  task automatic decode(input logic [41:0] bus, input exp_t e);
    @(negedge clk);
    segments = bus;
    start    = 1'b1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_in_decode", {31'h0, busy}, 32'd1);
    wait_done(7);
  endtask

  initial begin
    logic [41:0] bus;
    int          d0;
    rst = 1'b1; start = 1'b0; segments = '1;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'h0, busy}, 32'd0);
    chk("rst_done",  {31'h0, done}, 32'd0);
    chk("rst_data",  {8'h0, data}, 32'd0);
    chk("rst_en",    {29'h0, enable}, 32'd0);
    chk("rst_valid", {26'h0, digit_valid}, 32'd0);
    chk("rst_error", {31'h0, error}, 32'd0);
    rst = 1'b0;

    decode(enc(24'h123456, 3'b111), '{24'h123456, 3'b111, 6'h3F, 1'b0});
    decode(enc(24'hABCDEF, 3'b010), '{24'h00CD00, 3'b010, 6'h0C, 1'b0});

    bus = enc(24'h000000, 3'b111);
    bus[27:21] = ~7'h01;
    decode(bus, '{24'h000000, 3'b111, 6'h37, 1'b1});

    bus = enc(24'h000000, 3'b111);
    bus[6:0] = ~7'h27;
`ifdef QA_7SEG_DEC_ALT_GLYPH_EN
    decode(bus, '{24'h000007, 3'b111, 6'h3F, 1'b0});
`else
    decode(bus, '{24'h000000, 3'b111, 6'h3E, 1'b1});
`endif

    // Reset while decoding digit 3: no done may follow.
    @(negedge clk);
    segments = enc(24'h123456, 3'b111);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    d0 = n_done;
    rst = 1'b1;
    #1;
    chk("midrst_busy",  {31'h0, busy}, 32'd0);
    chk("midrst_data",  {8'h0, data}, 32'd0);
    chk("midrst_en",    {29'h0, enable}, 32'd0);
    chk("midrst_valid", {26'h0, digit_valid}, 32'd0);
    chk("midrst_error", {31'h0, error}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", n_done, d0);
    decode(enc(24'h654321, 3'b101), '{24'h650021, 3'b101, 6'h33, 1'b0});

    // Start and bus change while busy are ignored.
    d0 = n_done;
    @(negedge clk);
    segments = enc(24'h9A0F21, 3'b111);
    start = 1'b1;
    q.push_back('{24'h9A0F21, 3'b111, 6'h3F, 1'b0});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    segments = enc(24'h555555, 3'b011);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(-1);
    repeat (12) @(negedge clk);
    chk("single_done", n_done - d0, 32'd1);
    chk("queue_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
